alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle for alu_arbiter: two requesters, the external ALU and the response consumer.
// Optional macro ALU_ARBITER_ZERO_FLAG_EN adds the RSP_ZERO signal.
interface alu_arbiter_if;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_READY;
  logic [5:0]  REQ_OP;
  logic [15:0] REQ_A;
  logic [15:0] REQ_B;
  logic [7:0]  ALU_DATA1;
  logic [7:0]  ALU_DATA2;
  logic [2:0]  ALU_SELECT;
  logic [7:0]  ALU_RESULT;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic        RSP_ID;
  logic [7:0]  RSP_DATA;
  logic        RSP_ERR;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
  logic        RSP_ZERO;

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    output REQ_READY, ALU_DATA1, ALU_DATA2, ALU_SELECT,
           RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, RSP_ZERO
  );
  modport master (
    output REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    input  REQ_READY, ALU_DATA1, ALU_DATA2, ALU_SELECT,
           RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, RSP_ZERO
  );
`else
  modport slave (
    input  REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    output REQ_READY, ALU_DATA1, ALU_DATA2, ALU_SELECT,
           RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR
  );
  modport master (
    output REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    input  REQ_READY, ALU_DATA1, ALU_DATA2, ALU_SELECT,
           RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR
  );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for a shared fixed-latency ALU.
// Two requesters compete; one op is in flight at a time (IDLE -> EXEC -> RESP).
// Op codes 100-111 are unsupported and answered immediately with RSP_ERR.
// ALU_LAT (1..15) is the number of cycles from operand change to a valid
// ALU_RESULT; the result is captured exactly ALU_LAT edges after the transfer.
// Optional macro ALU_ARBITER_ZERO_FLAG_EN adds RSP_ZERO (captured result == 0).
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input  logic          CLK,
  input  logic          RESETN,
  alu_arbiter_if.slave  bus
);

  localparam int         NUM_REQ  = 2;
  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q,    state_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic        last_q,     last_d;
  logic [7:0]  data1_q,    data1_d;
  logic [7:0]  data2_q,    data2_d;
  logic [2:0]  sel_q,      sel_d;
  logic        rsp_id_q,   rsp_id_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q,  rsp_err_d;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
  logic        rsp_zero_q, rsp_zero_d;
`endif

  // per-requester views of the packed request buses
  logic [NUM_REQ-1:0][2:0] op_lane;
  logic [NUM_REQ-1:0][7:0] a_lane;
  logic [NUM_REQ-1:0][7:0] b_lane;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign op_lane[i] = bus.REQ_OP[3*i +: 3];
    assign a_lane[i]  = bus.REQ_A[8*i +: 8];
    assign b_lane[i]  = bus.REQ_B[8*i +: 8];
  end

  logic       gnt_idx;
  logic [1:0] req_ready;
  logic       xfer;
  logic [2:0] gnt_op;
  logic [7:0] gnt_a;
  logic [7:0] gnt_b;

  // arbitration: sole requester wins, a tie goes to whoever did not win last;
  // ready is gated by RESETN so nothing is offered while reset is held
  always_comb begin
    gnt_idx   = 1'b0;
    req_ready = 2'b00;
    if (bus.REQ_VALID == 2'b11) gnt_idx = ~last_q;
    else                        gnt_idx = bus.REQ_VALID[1];
    if ((state_q == IDLE) && RESETN && (|bus.REQ_VALID))
      req_ready = gnt_idx ? 2'b10 : 2'b01;
  end

  assign xfer   = |(bus.REQ_VALID & req_ready);
  assign gnt_op = op_lane[gnt_idx];
  assign gnt_a  = a_lane[gnt_idx];
  assign gnt_b  = b_lane[gnt_idx];

  // next-state and datapath updates for the three-state sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    sel_d      = sel_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    rsp_zero_d = rsp_zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          rsp_id_d = gnt_idx;
          last_d   = gnt_idx;
          if (!gnt_op[2]) begin
            // supported op: drive the ALU and wait out its latency
            data1_d = gnt_a;
            data2_d = gnt_b;
            sel_d   = gnt_op;
            cnt_d   = LAT_LOAD;
            state_d = EXEC;
          end else begin
            // unsupported op: ALU untouched, answer immediately
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b1;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
            rsp_zero_d = 1'b0;
`endif
            state_d    = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        // <= rather than == so a zero count can never strand the FSM
        if (cnt_q <= 4'd1) begin
          rsp_data_d = bus.ALU_RESULT;
          rsp_err_d  = 1'b0;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
          rsp_zero_d = (bus.ALU_RESULT == 8'h00);
`endif
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset discards any op in flight
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      data1_q    <= 8'h00;
      data2_q    <= 8'h00;
      sel_q      <= 3'b000;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
      rsp_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      sel_q      <= sel_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
      rsp_zero_q <= rsp_zero_d;
`endif
    end
  end

  assign bus.REQ_READY  = req_ready;
  assign bus.ALU_DATA1  = data1_q;
  assign bus.ALU_DATA2  = data2_q;
  assign bus.ALU_SELECT = sel_q;
  assign bus.RSP_VALID  = (state_q == RESP);
  assign bus.RSP_ID     = rsp_id_q;
  assign bus.RSP_DATA   = rsp_data_q;
  assign bus.RSP_ERR    = rsp_err_q;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
  assign bus.RSP_ZERO   = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered ALU model (ALU_LAT = 2).
// ALU model: 000 forward DATA2, 001 add, 010 and, 011 or.
module tb_alu_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter #(.ALU_LAT(LAT)) dut (
    .CLK    (clk),
    .RESETN (rstn),
    .bus    (bus)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'b000:  return b;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return 8'h00;
    endcase
  endfunction

  // one register stage: result is valid one cycle after operands change
  logic [7:0] alu_q;
  always @(posedge clk) alu_q <= alu_f(bus.ALU_SELECT, bus.ALU_DATA1, bus.ALU_DATA2);
  assign bus.ALU_RESULT = alu_q;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       err;
    logic       zero;
    int         t_xfer;
    int         lat;
  } exp_t;

  exp_t sbq[$];

  // reference model state
  logic       m_busy = 1'b0;
  logic       m_last = 1'b1;
  logic [7:0] m_d1 = 8'h00;
  logic [7:0] m_d2 = 8'h00;
  logic [2:0] m_sel = 3'b000;
  logic       rsp_seen = 1'b0;
  int         n_xfer = 0;

  logic [1:0] erdy;
  logic       g;
  logic [2:0] mop;
  logic [7:0] ma, mb;
  exp_t       e;

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // monitor: predicts handshakes, pushes expectations, checks responses
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_rsp_valid", bus.RSP_VALID, 0);
      chk("rst_req_ready", bus.REQ_READY, 0);
      chk("rst_rsp_data",  bus.RSP_DATA, 0);
      sbq.delete();
      m_busy = 1'b0; m_last = 1'b1; m_d1 = 8'h00; m_d2 = 8'h00; m_sel = 3'b000;
      rsp_seen = 1'b0;
    end else begin
      erdy = m_busy ? 2'b00 : exp_grant(bus.REQ_VALID, m_last);
      chk("req_ready",  bus.REQ_READY,  erdy);
      chk("alu_data1",  bus.ALU_DATA1,  m_d1);
      chk("alu_data2",  bus.ALU_DATA2,  m_d2);
      chk("alu_select", bus.ALU_SELECT, m_sel);
      if (|(bus.REQ_VALID & erdy)) begin
        g   = erdy[1];
        mop = g ? bus.REQ_OP[5:3]  : bus.REQ_OP[2:0];
        ma  = g ? bus.REQ_A[15:8]  : bus.REQ_A[7:0];
        mb  = g ? bus.REQ_B[15:8]  : bus.REQ_B[7:0];
        e.id     = g;
        e.err    = mop[2];
        e.data   = mop[2] ? 8'h00 : alu_f(mop, ma, mb);
        e.zero   = !e.err && (e.data == 8'h00);
        e.t_xfer = cyc;
        e.lat    = mop[2] ? 1 : LAT + 1;
        sbq.push_back(e);
        m_busy = 1'b1;
        m_last = g;
        n_xfer++;
        if (!mop[2]) begin m_d1 = ma; m_d2 = mb; m_sel = mop; end
      end
      if (bus.RSP_VALID) begin
        if (sbq.size() == 0) chk("rsp_unexpected", bus.RSP_VALID, 0);
        else begin
          if (!rsp_seen) begin
            chk("rsp_latency", cyc - sbq[0].t_xfer, sbq[0].lat);
            rsp_seen = 1'b1;
          end
          chk("rsp_id",   bus.RSP_ID,   sbq[0].id);
          chk("rsp_data", bus.RSP_DATA, sbq[0].data);
          chk("rsp_err",  bus.RSP_ERR,  sbq[0].err);
`ifdef ALU_ARBITER_ZERO_FLAG_EN
          chk("rsp_zero", bus.RSP_ZERO, sbq[0].zero);
`endif
          if (bus.RSP_READY) begin
            void'(sbq.pop_front());
            rsp_seen = 1'b0;
            m_busy   = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    @(posedge clk); #1;
    if (i == 0) begin bus.REQ_OP[2:0] = op; bus.REQ_A[7:0]  = a; bus.REQ_B[7:0]  = b; end
    else        begin bus.REQ_OP[5:3] = op; bus.REQ_A[15:8] = a; bus.REQ_B[15:8] = b; end
    bus.REQ_VALID[i] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (bus.REQ_READY[i]) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", bus.REQ_READY[i], 1);
    @(posedge clk); #1;
    bus.REQ_VALID[i] = 1'b0;
  endtask

  task automatic wait_drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
      if (rnd) bus.RSP_READY = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (sbq.size() == 0 && !m_busy) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(sbq.size()), 0);
    bus.RSP_READY = 1'b1;
  endtask

  initial begin
    int start;
    bit seen;
    bus.REQ_VALID = 2'b00;
    bus.REQ_OP    = '0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_data1",  bus.ALU_DATA1,  0);
    chk("rst_alu_data2",  bus.ALU_DATA2,  0);
    chk("rst_alu_select", bus.ALU_SELECT, 0);
    chk("rst_rsp_id",     bus.RSP_ID,     0);
    chk("rst_rsp_err",    bus.RSP_ERR,    0);
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    chk("rst_rsp_zero",   bus.RSP_ZERO,   0);
`endif
    rstn = 1'b1;

    // single ADD from requester 0: 5 + 3
    send(0, 3'b001, 8'd5, 8'd3);
    chk("add_select", bus.ALU_SELECT, 3'b001);
    wait_drain(0);

    // both requesters valid continuously: AND / OR alternating
    @(posedge clk); #1;
    bus.REQ_OP = {3'b011, 3'b010};
    bus.REQ_A  = {8'h0F, 8'hF0};
    bus.REQ_B  = {8'h30, 8'h3C};
    bus.REQ_VALID = 2'b11;
    start = n_xfer;
    for (int k = 0; k < 100 && n_xfer < start + 4; k++) @(negedge clk);
    chk("rr_xfer_count", n_xfer - start >= 4, 1);
    @(posedge clk); #1;
    bus.REQ_VALID = 2'b00;
    wait_drain(0);

    // unsupported op: immediate error response, ALU regs untouched
    send(0, 3'b111, 8'h11, 8'h22);
    wait_drain(0);

    // consumer stall for 5 cycles while requester 0 waits
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;
    send(1, 3'b001, 8'd10, 8'd20);
    bus.REQ_OP[2:0] = 3'b010; bus.REQ_A[7:0] = 8'hAA; bus.REQ_B[7:0] = 8'h0F;
    bus.REQ_VALID[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.RSP_VALID) seen = 1'b1;
    end
    chk("stall_rsp_seen", bus.RSP_VALID, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", bus.RSP_VALID, 1);
      chk("stall_rsp_data",  bus.RSP_DATA, 8'd30);
      chk("stall_req_ready", bus.REQ_READY, 2'b00);
    end
    @(posedge clk); #1;
    bus.RSP_READY = 1'b1;
    send(0, 3'b010, 8'hAA, 8'h0F);
    wait_drain(0);

    // reset pulse during EXEC: outputs clear at once, no response afterwards
    send(0, 3'b001, 8'd1, 8'd2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_rsp_valid", bus.RSP_VALID, 0);
    chk("arst_rsp_data",  bus.RSP_DATA, 0);
    chk("arst_rsp_id",    bus.RSP_ID, 0);
    chk("arst_rsp_err",   bus.RSP_ERR, 0);
    chk("arst_alu_data1", bus.ALU_DATA1, 0);
    chk("arst_alu_data2", bus.ALU_DATA2, 0);
    chk("arst_alu_sel",   bus.ALU_SELECT, 0);
    bus.REQ_VALID[1] = 1'b1;
    #1;
    chk("arst_req_ready", bus.REQ_READY, 2'b00);
    @(posedge clk); #1;
    bus.REQ_VALID = 2'b00;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_rsp", bus.RSP_VALID, 0);

    // forward op: zero and non-zero results
    send(0, 3'b000, 8'h55, 8'h00);
    wait_drain(0);
    send(0, 3'b000, 8'h55, 8'h07);
    wait_drain(0);

    // random mix with a randomly stalling consumer
    for (int k = 0; k < 12; k++) begin
      send($urandom_range(0, 1), 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_drain(1);
    end

    chk("final_queue_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
